// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART TX scheduler
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } sched_state_e;

  localparam int DataBits = 8;
  localparam int MinDiv   = 2;

  // Parity bit that makes the data-plus-parity ones count even (odd=0) or odd (odd=1)
  function automatic logic frame_parity(input logic [DataBits-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit down-counter, reloaded on every bit entry
module uart_bit_timer
  import uart_tx_sched_pkg::*;
#(
  parameter int DivW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [DivW-1:0] div_i,
  output logic            bit_end_o
);

  logic [DivW-1:0] cnt_q;
  logic [DivW-1:0] period_m1;

  // Clamp the divisor so a bit never lasts fewer than MinDiv cycles
  always_comb begin
    if (div_i < DivW'(MinDiv)) begin
      period_m1 = DivW'(MinDiv - 1);
    end else begin
      period_m1 = div_i - DivW'(1);
    end
  end

  // Reload on bit entry, otherwise count down and park at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= period_m1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DivW'(1);
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin shared UART transmitter with baud timer and framer
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int NumReq = 4,
  parameter  int DivW   = 16,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq*8-1:0]    req_data_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [DivW-1:0]        clk_div_i,
  input  logic                   parity_en_i,
  input  logic                   parity_odd_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   frame_done_o
);

  sched_state_e          state_q, state_n;
  logic [2:0]            bit_cnt_q, bit_cnt_n;
  logic                  tx_q, tx_n;
  logic                  busy_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [IdxW-1:0]       grant_idx_q;

  logic [DataBits-1:0]   data_q;
  logic [DivW-1:0]       div_q;
  logic                  par_en_q;
  logic                  par_odd_q;

  logic                  grant_any;
  logic [IdxW-1:0]       grant_idx;
  logic [NumReq-1:0]     grant_oh;
  logic [IdxW:0]         cand;
  logic [IdxW-1:0]       cand_idx;

  logic                  handshake;
  logic                  timer_load;
  logic [DivW-1:0]       timer_div;
  logic                  bit_end;

  // Rotating priority search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      cand_idx = cand[IdxW-1:0];
      if (!grant_any && req_valid_i[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    grant_oh[grant_idx] = grant_any;
  end

  assign handshake   = (state_q == IDLE) && grant_any;
  assign req_ready_o = (state_q == IDLE) ? grant_oh : '0;

  // The accept cycle loads the timer from the live divisor; later bits use the captured one
  assign timer_div = handshake ? clk_div_i : div_q;

  uart_bit_timer #(
    .DivW (DivW)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (timer_load),
    .div_i     (timer_div),
    .bit_end_o (bit_end)
  );

  // Frame sequencing and the line level for whichever bit is being entered
  always_comb begin
    state_n      = state_q;
    bit_cnt_n    = bit_cnt_q;
    timer_load   = 1'b0;
    frame_done_o = 1'b0;
    tx_n         = 1'b1;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_n    = START;
          timer_load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          bit_cnt_n  = '0;
          timer_load = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_load = 1'b1;
          if (bit_cnt_q == 3'(DataBits - 1)) begin
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n    = STOP;
          timer_load = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n      = IDLE;
          frame_done_o = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_q[bit_cnt_n];
      PARITY:  tx_n = frame_parity(data_q, par_odd_q);
      default: tx_n = 1'b1;
    endcase
  end

  // State, registered line/busy outputs and round-robin bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      tx_q      <= tx_n;
      busy_q    <= (state_n != IDLE);
      if (handshake) begin
        grant_idx_q <= grant_idx;
        rr_ptr_q    <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
      end
    end
  end

  // Frame parameters frozen at accept so later input changes cannot disturb the frame
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      data_q    <= req_data_i[grant_idx*DataBits +: DataBits];
      div_q     <= clk_div_i;
      par_en_q  <= parity_en_i;
      par_odd_q <= parity_odd_i;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NUM = 4;
  localparam int DW  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM-1:0]   req_valid;
  logic [NUM*8-1:0] req_data;
  logic [NUM-1:0]   req_ready;
  logic [DW-1:0]    clk_div;
  logic             parity_en;
  logic             parity_odd;
  logic             tx;
  logic             busy;
  logic [1:0]       grant_idx;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(
    .NumReq (NUM),
    .DivW   (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .clk_div_i    (clk_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .tx_o         (tx),
    .busy_o       (busy),
    .grant_idx_o  (grant_idx),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  // model state
  bit          armed = 1'b0;
  longint      cyc = 0;
  bit          have_frame = 1'b0;
  longint      f_t = 0;
  int          f_len = 0;
  int          f_d = 2;
  logic [10:0] f_bits = '0;
  int          m_rr = 0;
  int          m_gidx = 0;
  bit          m_hs = 1'b0;
  int          m_hs_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a frame accepted at cycle T is a list of line bits, bit j
  // occupies cycles T+1+j*D .. T+(j+1)*D; the scheduler is free again after it.
  always @(negedge clk) begin
    if (armed) begin
      int          k;
      bit          idle;
      bit          active;
      bit          hs;
      int          hs_idx;
      logic [3:0]  exp_ready;
      logic        exp_tx;
      k        = int'(cyc - f_t);
      active   = have_frame && (k >= 1) && (k <= f_len);
      idle     = !have_frame || (k > f_len);
      hs       = 1'b0;
      hs_idx   = 0;
      exp_ready = '0;
      if (idle) begin
        for (int s = 0; s < NUM; s++) begin
          int idx;
          idx = (m_rr + s) % NUM;
          if (!hs && req_valid[idx]) begin
            hs = 1'b1;
            hs_idx = idx;
          end
        end
        if (hs) exp_ready[hs_idx] = 1'b1;
      end
      exp_tx = active ? f_bits[(k - 1) / f_d] : 1'b1;
      chk("m_ready", req_ready, exp_ready);
      chk("m_tx", tx, exp_tx);
      chk("m_busy", busy, active);
      chk("m_done", frame_done, have_frame && (k == f_len));
      chk("m_grant_idx", grant_idx, m_gidx);
      if (rst) begin
        have_frame = 1'b0;
        m_rr = 0;
        m_gidx = 0;
        m_hs = 1'b0;
      end else if (hs) begin
        logic [7:0] d;
        int         n;
        d = req_data[hs_idx*8 +: 8];
        f_d = (clk_div < 2) ? 2 : int'(clk_div);
        f_bits = '0;
        f_bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) f_bits[1 + b] = d[b];
        n = 9;
        if (parity_en) begin
          f_bits[9] = (^d) ^ parity_odd;
          n = 10;
        end
        f_bits[n] = 1'b1;
        f_len = (n + 1) * f_d;
        f_t = cyc;
        have_frame = 1'b1;
        m_gidx = hs_idx;
        m_rr = (hs_idx + 1) % NUM;
        m_hs = 1'b1;
        m_hs_idx = hs_idx;
      end else begin
        m_hs = 1'b0;
      end
      cyc++;
    end
  end

  task automatic wait_grant(output int idx, output bit ok);
    ok = 1'b0;
    idx = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NUM; i++) if (req_ready[i]) idx = i;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout cycle %0d: got no ready expected ready within 200 cycles", cyc);
    end
  endtask

  // Send one byte alone and check the line against a hand-written bit list
  task automatic send_frame(input int idx, input logic [7:0] data, input int div,
                            input bit pen, input bit podd, input int pulse_idx,
                            input logic [10:0] bits, input int nb, input int d);
    int g;
    bit ok;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[idx*8 +: 8] = data;
    clk_div = DW'(div);
    parity_en = pen;
    parity_odd = podd;
    wait_grant(g, ok);
    if (!ok) return;
    chk("lit_grant_sel", g, idx);
    @(posedge clk); #1;
    req_valid = '0;
    req_data = {$urandom, $urandom};
    clk_div = DW'(div + 7);
    parity_en = !pen;
    parity_odd = !podd;
    for (int k = 1; k <= nb * d + 1; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (pulse_idx >= 0) req_valid[pulse_idx] = (k == 5);
      @(negedge clk);
      if (k <= nb * d) chk("lit_tx", tx, bits[(k - 1) / d]);
      chk("lit_done", frame_done, k == nb * d);
      chk("lit_busy", busy, k <= nb * d);
      if (k == 1) chk("lit_grant_idx", grant_idx, idx);
      if (k == 5 && pulse_idx >= 0) chk("lit_busy_ready", req_ready, 0);
    end
  endtask

  initial begin
    int     g;
    bit     ok;
    int     order[5];
    longint tstart[5];
    int     exp_order[5];

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    clk_div = 16'd4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    @(posedge clk); #1;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_done", frame_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin with all four holding valid
    exp_order = '{0, 1, 2, 3, 0};
    clk_div = 16'd2;
    parity_en = 1'b0;
    req_data = 32'h44332211;
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, ok);
      if (!ok) break;
      order[n] = g;
      tstart[n] = longint'($time);
      chk("rr_order", order[n], exp_order[n]);
      if (n > 0) chk("rr_period", 32'(int'((tstart[n] - tstart[n-1]) / 10)), 21);
      @(posedge clk); #1;
      if (n == 0) req_data[7:0] = 8'h55;
      else req_valid[g] = 1'b0;
      if (n == 4) req_valid = '0;
    end

    // single frame, then parity even/odd
    send_frame(0, 8'hA5, 4, 1'b0, 1'b0, -1, 11'({1'b1, 8'hA5, 1'b0}), 10, 4);
    send_frame(0, 8'h07, 3, 1'b1, 1'b0, -1, 11'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 3);
    send_frame(0, 8'h07, 3, 1'b1, 1'b1, -1, 11'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 3);
    // divisor clamping
    send_frame(1, 8'h3C, 0, 1'b0, 1'b0, -1, 11'({1'b1, 8'h3C, 1'b0}), 10, 2);
    send_frame(2, 8'hC3, 1, 1'b1, 1'b1, -1, 11'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, 2);
    // valid pulsed while busy
    send_frame(3, 8'h5A, 2, 1'b0, 1'b0, 2, 11'({1'b1, 8'h5A, 1'b0}), 10, 2);

    // reset in the middle of DATA
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h99;
    clk_div = 16'd3;
    parity_en = 1'b0;
    wait_grant(g, ok);
    chk("rst_pre_grant", g, 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rr", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (40) @(posedge clk);
    send_frame(2, 8'h42, 3, 1'b0, 1'b0, -1, 11'({1'b1, 8'h42, 1'b0}), 10, 3);

    // randomized traffic against the model
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 1999) == 0);
      for (int i = 0; i < NUM; i++) begin
        if (req_valid[i] && m_hs && m_hs_idx == i) begin
          req_valid[i] = ($urandom_range(0, 3) == 0);
          if (req_valid[i]) req_data[i*8 +: 8] = 8'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      clk_div = DW'($urandom_range(0, 5));
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
